// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 subsystem port bridge: FSM encodings,
// arbitration grant type and Avalon addressing constants.
package ddr2_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_ACK   = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_RD_ACK   = 3'd5;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  // Byte address to 32-bit word address
  localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/ddr2_port_bridge.sv
// Terminates the frame buffer's single-word write/read ports and turns each
// accepted request into one Avalon-MM transaction on the DDR2 local port.
module ddr2_port_bridge
  import ddr2_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                AVM_ADDR_W   = 25,
  parameter int                RD_TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic                  ctrl_clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W-1:0]     write_iData,
  input  logic                  write,
  output logic                  write_waitrequest,
  input  logic [ADDR_W-1:0]     read_addr,
  input  logic                  read,
  output logic [DATA_W-1:0]     oData,
  output logic                  read_waitrequest,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_read,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic                  err_timeout,
  output logic                  err_stray,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  localparam int              TO_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [2:0]      state_r;
  grant_e          last_grant_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            unused_addr_bits_s;

  assign avm_byteenable = {(DATA_W/8){1'b1}};

  // Sub-word and above-range address bits carry no meaning for the controller
  assign unused_addr_bits_s = ^{write_addr[ADDR_SHIFT-1:0], read_addr[ADDR_SHIFT-1:0],
                                write_addr[ADDR_W-1:AVM_ADDR_W+ADDR_SHIFT],
                                read_addr[ADDR_W-1:AVM_ADDR_W+ADDR_SHIFT]};

  // Request arbitration, Avalon sequencing, read timeout and status counters
  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      last_grant_r      <= GRANT_READ;
      to_cnt_r          <= '0;
      write_waitrequest <= 1'b1;
      read_waitrequest  <= 1'b1;
      avm_write         <= 1'b0;
      avm_read          <= 1'b0;
      avm_address       <= '0;
      avm_writedata     <= '0;
      oData             <= '0;
      err_timeout       <= 1'b0;
      err_stray         <= 1'b0;
      wr_count          <= 16'd0;
      rd_count          <= 16'd0;
    end else begin
      // Read data arriving while no read is waiting is discarded and flagged
      if (avm_readdatavalid && (state_r != S_RD_WAIT)) begin
        err_stray <= 1'b1;
      end

      case (state_r)
        S_IDLE: begin
          if (write && (!read || (last_grant_r == GRANT_READ))) begin
            state_r       <= S_WR_ISSUE;
            last_grant_r  <= GRANT_WRITE;
            avm_write     <= 1'b1;
            avm_address   <= write_addr[AVM_ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
            avm_writedata <= write_iData;
          end else if (read) begin
            state_r      <= S_RD_ISSUE;
            last_grant_r <= GRANT_READ;
            avm_read     <= 1'b1;
            avm_address  <= read_addr[AVM_ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
          end
        end
        S_WR_ISSUE: begin
          if (!avm_waitrequest) begin
            state_r           <= S_WR_ACK;
            avm_write         <= 1'b0;
            write_waitrequest <= 1'b0;
          end
        end
        S_WR_ACK: begin
          state_r           <= S_IDLE;
          write_waitrequest <= 1'b1;
          wr_count          <= wr_count + 16'd1;
        end
        S_RD_ISSUE: begin
          if (!avm_waitrequest) begin
            state_r  <= S_RD_WAIT;
            avm_read <= 1'b0;
            to_cnt_r <= '0;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            state_r          <= S_RD_ACK;
            oData            <= avm_readdata;
            read_waitrequest <= 1'b0;
          end else if (to_cnt_r == TO_LAST) begin
            state_r          <= S_RD_ACK;
            oData            <= TIMEOUT_DATA;
            err_timeout      <= 1'b1;
            read_waitrequest <= 1'b0;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        S_RD_ACK: begin
          state_r          <= S_IDLE;
          read_waitrequest <= 1'b1;
          rd_count         <= rd_count + 16'd1;
        end
        default: begin
          state_r           <= S_IDLE;
          write_waitrequest <= 1'b1;
          read_waitrequest  <= 1'b1;
          avm_write         <= 1'b0;
          avm_read          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_port_bridge.sv
// Directed self-checking bench for ddr2_port_bridge with a small Avalon
// responder model (configurable waitrequest and read latency).
module tb_ddr2_port_bridge;

  logic        ctrl_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] write_addr = 32'd0;
  logic [31:0] write_iData = 32'd0;
  logic        write = 1'b0;
  logic        write_waitrequest;
  logic [31:0] read_addr = 32'd0;
  logic        read = 1'b0;
  logic [31:0] oData;
  logic        read_waitrequest;
  logic [24:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b1;
  logic        err_timeout;
  logic        err_stray;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int pass_n = 0;
  int total_n = 0;

  ddr2_port_bridge dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n),
    .write_addr(write_addr), .write_iData(write_iData), .write(write),
    .write_waitrequest(write_waitrequest),
    .read_addr(read_addr), .read(read), .oData(oData),
    .read_waitrequest(read_waitrequest),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .err_timeout(err_timeout), .err_stray(err_stray),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  // ---------------- Avalon responder model ----------------
  int          cfg_wait = 0;
  int          cfg_lat = 1;
  bit          cfg_respond = 1'b1;
  int          stray_req_n = 0;
  int          stray_done_n = 0;
  bit          in_req = 1'b0;
  int          busy_cnt = 0;
  int          lat_cnt = 0;
  logic [24:0] pend_addr = 25'd0;
  int          log_n = 0;
  bit          log_wr [0:63];
  logic [24:0] log_addr [0:63];
  logic [31:0] log_wdata [0:63];

  function automatic logic [31:0] rd_data_of(input logic [24:0] a);
    if (a == 25'd8) return 32'h1234_5678;
    return 32'hC0DE_0000 | {7'd0, a};
  endfunction

  always @(posedge ctrl_clk) begin
    #1;
    avm_readdatavalid = 1'b0;
    if (!reset_n) begin
      in_req = 1'b0;
      lat_cnt = 0;
      avm_waitrequest = 1'b1;
    end else begin
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && cfg_respond) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rd_data_of(pend_addr);
        end
      end
      if (stray_req_n != stray_done_n) begin
        stray_done_n = stray_req_n;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'h5555_AAAA;
      end
      if (avm_write || avm_read) begin
        if (!in_req) begin
          in_req = 1'b1;
          busy_cnt = cfg_wait;
        end
        if (busy_cnt > 0) begin
          avm_waitrequest = 1'b1;
          busy_cnt--;
        end else begin
          avm_waitrequest = 1'b0;
          in_req = 1'b0;
          if (log_n < 64) begin
            log_wr[log_n] = avm_write;
            log_addr[log_n] = avm_address;
            log_wdata[log_n] = avm_writedata;
            log_n++;
          end
          if (avm_read) begin
            pend_addr = avm_address;
            lat_cnt = cfg_lat;
          end
        end
      end else begin
        avm_waitrequest = 1'b1;
      end
    end
  end

  int avm_wr_cyc = 0;
  int wr_ack_n = 0;
  int rd_ack_n = 0;

  // Cycle monitor for Avalon write strobes and port acknowledges
  always @(negedge ctrl_clk) begin
    if (avm_write) avm_wr_cyc++;
    if (!write_waitrequest) wr_ack_n++;
    if (!read_waitrequest) rd_ack_n++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge ctrl_clk);
    reset_n = 1'b0;
    write = 1'b0;
    read = 1'b0;
    repeat (2) @(negedge ctrl_clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_ack(input bit is_rd, input int max, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < max) begin
      @(negedge ctrl_clk);
      n++;
      if (is_rd ? !read_waitrequest : !write_waitrequest) ok = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    total_n++; if (write_waitrequest !== 1'b1) $display("FAIL %s write_waitrequest: got %b want 1", tag, write_waitrequest); else pass_n++;
    total_n++; if (read_waitrequest !== 1'b1) $display("FAIL %s read_waitrequest: got %b want 1", tag, read_waitrequest); else pass_n++;
    total_n++; if ({avm_write, avm_read} !== 2'b00) $display("FAIL %s avm_write/read: got %b want 00", tag, {avm_write, avm_read}); else pass_n++;
    total_n++; if (avm_address !== 25'd0) $display("FAIL %s avm_address: got %h want 0", tag, avm_address); else pass_n++;
    total_n++; if (avm_writedata !== 32'd0) $display("FAIL %s avm_writedata: got %h want 0", tag, avm_writedata); else pass_n++;
    total_n++; if (oData !== 32'd0) $display("FAIL %s oData: got %h want 0", tag, oData); else pass_n++;
    total_n++; if ({err_timeout, err_stray} !== 2'b00) $display("FAIL %s err flags: got %b want 00", tag, {err_timeout, err_stray}); else pass_n++;
    total_n++; if ({wr_count, rd_count} !== 32'd0) $display("FAIL %s counts: got %0d/%0d want 0/0", tag, wr_count, rd_count); else pass_n++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge ctrl_clk);
    check_reset_values("reset");
    total_n++; if (avm_byteenable !== 4'hF) $display("FAIL reset byteenable: got %h want f", avm_byteenable); else pass_n++;
  endtask

  task automatic test_both();
    int base, wb, rb, acks, n;
    do_reset();
    cfg_wait = 0; cfg_lat = 2; cfg_respond = 1'b1;
    base = log_n; wb = wr_ack_n; rb = rd_ack_n; acks = 0; n = 0;
    @(negedge ctrl_clk);
    write_addr = 32'h0000_0043; write_iData = 32'h1111_0000;
    read_addr = 32'h0000_0080;
    write = 1'b1; read = 1'b1;
    while (acks < 3 && n < 80) begin
      @(negedge ctrl_clk);
      n++;
      if (!write_waitrequest) begin
        acks++;
        write_addr = 32'h0000_0044; write_iData = 32'h2222_0000;
      end
      if (!read_waitrequest) acks++;
    end
    write = 1'b0; read = 1'b0;
    total_n++; if (acks !== 3) $display("FAIL both ack_budget: got %0d acks want 3", acks); else pass_n++;
    repeat (3) @(posedge ctrl_clk);
    #1;
    total_n++; if (log_n - base !== 3) $display("FAIL both txn_count: got %0d want 3", log_n - base); else pass_n++;
    total_n++; if ({log_wr[base], log_wr[base+1], log_wr[base+2]} !== 3'b101) $display("FAIL both grant_order: got %b want 101", {log_wr[base], log_wr[base+1], log_wr[base+2]}); else pass_n++;
    total_n++; if (log_addr[base] !== 25'h10) $display("FAIL both unaligned_waddr: got %h want 10", log_addr[base]); else pass_n++;
    total_n++; if (log_addr[base+1] !== 25'h20) $display("FAIL both raddr: got %h want 20", log_addr[base+1]); else pass_n++;
    total_n++; if (log_addr[base+2] !== 25'h11 || log_wdata[base+2] !== 32'h2222_0000) $display("FAIL both second_write: got %h/%h want 11/22220000", log_addr[base+2], log_wdata[base+2]); else pass_n++;
    total_n++; if (wr_ack_n - wb !== 2 || rd_ack_n - rb !== 1) $display("FAIL both ack_cycles: got %0d/%0d want 2/1", wr_ack_n - wb, rd_ack_n - rb); else pass_n++;
    total_n++; if (wr_count !== 16'd2 || rd_count !== 16'd1) $display("FAIL both counts: got %0d/%0d want 2/1", wr_count, rd_count); else pass_n++;
  endtask

  task automatic test_single_write();
    int base, cb, n;
    bit ok;
    do_reset();
    cfg_wait = 0;
    base = log_n; cb = avm_wr_cyc;
    @(negedge ctrl_clk);
    write_addr = 32'h0000_0010; write_iData = 32'hA5A5_0001; write = 1'b1;
    wait_ack(1'b0, 20, n, ok);
    write = 1'b0;
    total_n++; if (!ok) $display("FAIL wr ack: got no ack want ack within 20 cycles"); else pass_n++;
    total_n++; if (n !== 2) $display("FAIL wr latency: got %0d want 2", n); else pass_n++;
    repeat (2) @(posedge ctrl_clk);
    #1;
    total_n++; if (log_n - base !== 1 || log_addr[base] !== 25'd4 || log_wdata[base] !== 32'hA5A5_0001) $display("FAIL wr avm_txn: got n=%0d addr=%h data=%h want 1/4/a5a50001", log_n - base, log_addr[base], log_wdata[base]); else pass_n++;
    total_n++; if (avm_wr_cyc - cb !== 1) $display("FAIL wr avm_write_cycles: got %0d want 1", avm_wr_cyc - cb); else pass_n++;
    total_n++; if (wr_count !== 16'd1) $display("FAIL wr count: got %0d want 1", wr_count); else pass_n++;
    total_n++; if (write_waitrequest !== 1'b1) $display("FAIL wr idle_wait: got %b want 1", write_waitrequest); else pass_n++;
  endtask

  task automatic test_single_read();
    int base, n;
    bit ok;
    do_reset();
    cfg_wait = 3; cfg_lat = 5; cfg_respond = 1'b1;
    base = log_n;
    @(negedge ctrl_clk);
    read_addr = 32'h0000_0020; read = 1'b1;
    wait_ack(1'b1, 40, n, ok);
    read = 1'b0;
    total_n++; if (!ok || n !== 10) $display("FAIL rd latency: got ok=%b n=%0d want ok=1 n=10", ok, n); else pass_n++;
    total_n++; if (oData !== 32'h1234_5678) $display("FAIL rd data: got %h want 12345678", oData); else pass_n++;
    total_n++; if (log_wr[base] !== 1'b0 || log_addr[base] !== 25'd8) $display("FAIL rd avm_addr: got wr=%b addr=%h want 0/8", log_wr[base], log_addr[base]); else pass_n++;
    @(negedge ctrl_clk);
    total_n++; if (read_waitrequest !== 1'b1 || oData !== 32'h1234_5678) $display("FAIL rd hold: got wait=%b data=%h want 1/12345678", read_waitrequest, oData); else pass_n++;
    total_n++; if (rd_count !== 16'd1) $display("FAIL rd count: got %0d want 1", rd_count); else pass_n++;
  endtask

  task automatic test_continuous_read();
    int base, rb, n;
    bit ok;
    do_reset();
    cfg_wait = 0; cfg_lat = 1; cfg_respond = 1'b1;
    base = log_n; rb = rd_ack_n;
    @(negedge ctrl_clk);
    read_addr = 32'd0; read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b1, 20, n, ok);
      total_n++; if (!ok || n !== ((i == 0) ? 3 : 4)) $display("FAIL cont latency%0d: got ok=%b n=%0d want ok=1 n=%0d", i, ok, n, (i == 0) ? 3 : 4); else pass_n++;
      total_n++; if (oData !== (32'hC0DE_0000 | i)) $display("FAIL cont data%0d: got %h want %h", i, oData, 32'hC0DE_0000 | i); else pass_n++;
      read_addr = (i + 1) * 4;
      if (i == 2) read = 1'b0;
    end
    repeat (4) @(posedge ctrl_clk);
    #1;
    total_n++; if (log_n - base !== 3) $display("FAIL cont txn_count: got %0d want 3", log_n - base); else pass_n++;
    total_n++; if ({log_addr[base], log_addr[base+1], log_addr[base+2]} !== {25'd0, 25'd1, 25'd2}) $display("FAIL cont addrs: got %0d,%0d,%0d want 0,1,2", log_addr[base], log_addr[base+1], log_addr[base+2]); else pass_n++;
    total_n++; if (rd_ack_n - rb !== 3 || rd_count !== 16'd3) $display("FAIL cont acks: got %0d cycles count=%0d want 3/3", rd_ack_n - rb, rd_count); else pass_n++;
    total_n++; if (err_stray !== 1'b0) $display("FAIL cont err_stray: got %b want 0", err_stray); else pass_n++;
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    cfg_wait = 0; cfg_lat = 1; cfg_respond = 1'b0;
    @(negedge ctrl_clk);
    read_addr = 32'h0000_0030; read = 1'b1;
    wait_ack(1'b1, 400, n, ok);
    read = 1'b0;
    total_n++; if (!ok || n !== 257) $display("FAIL tmo latency: got ok=%b n=%0d want ok=1 n=257", ok, n); else pass_n++;
    total_n++; if (oData !== 32'hDEAD_BEEF) $display("FAIL tmo data: got %h want deadbeef", oData); else pass_n++;
    total_n++; if (err_timeout !== 1'b1) $display("FAIL tmo flag: got %b want 1", err_timeout); else pass_n++;
    cfg_respond = 1'b1;
    @(negedge ctrl_clk);
    read_addr = 32'h0000_0034; read = 1'b1;
    wait_ack(1'b1, 20, n, ok);
    read = 1'b0;
    total_n++; if (!ok || oData !== 32'hC0DE_000D) $display("FAIL tmo next_read: got ok=%b data=%h want 1/c0de000d", ok, oData); else pass_n++;
    @(negedge ctrl_clk);
    total_n++; if (err_timeout !== 1'b1 || rd_count !== 16'd2) $display("FAIL tmo sticky: got flag=%b count=%0d want 1/2", err_timeout, rd_count); else pass_n++;
  endtask

  task automatic test_stray();
    total_n++; if (err_stray !== 1'b0) $display("FAIL stray pre: got %b want 0", err_stray); else pass_n++;
    stray_req_n++;
    repeat (3) @(negedge ctrl_clk);
    total_n++; if (err_stray !== 1'b1) $display("FAIL stray flag: got %b want 1", err_stray); else pass_n++;
    total_n++; if (oData !== 32'hC0DE_000D || read_waitrequest !== 1'b1) $display("FAIL stray data: got %h wait=%b want c0de000d/1", oData, read_waitrequest); else pass_n++;
  endtask

  task automatic test_reset_mid();
    cfg_respond = 1'b0;
    @(negedge ctrl_clk);
    read_addr = 32'h0000_0050; read = 1'b1;
    repeat (6) @(negedge ctrl_clk);
    read = 1'b0;
    total_n++; if (read_waitrequest !== 1'b1 || rd_count !== 16'd2) $display("FAIL midrst pre: got wait=%b count=%0d want 1/2", read_waitrequest, rd_count); else pass_n++;
    reset_n = 1'b0;
    @(negedge ctrl_clk);
    check_reset_values("midrst");
    reset_n = 1'b1;
    cfg_respond = 1'b1;
    repeat (2) @(negedge ctrl_clk);
  endtask

  initial begin
    test_reset();
    test_both();
    test_single_write();
    test_single_read();
    test_continuous_read();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
